// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, FSM state encodings and default timeout for the ALU multiply front end
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_EXEC   = 2'd2,
    S_OUT    = 2'd3
  } state_t;
endpackage

// File: rtl/productor_top.sv
// productor_top: combinational unsigned multiply truncated to DATA_W bits
module productor_top
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [DATA_W-1:0] result_o
);
  assign result_o = data0_i * data1_i;
endmodule

// File: rtl/operand_sequencer_top.sv
// operand_sequencer_top: collects A then B bytes, multiplies them and offers the registered product
module operand_sequencer_top
  import alu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [7:0]        op_count_o,
  output logic              err_timeout_o
);
  state_t state, state_n;
  logic [7:0] timer;
  logic [DATA_W-1:0] a_q, b_q, result;
  logic in_hs, out_hs, timeout_hit;
  assign in_ready_o  = (state == S_IDLE) || (state == S_WAIT_B);
  assign out_valid_o = (state == S_OUT);
  assign in_hs       = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_o && out_ready_i;
  // a B handshake on the expiry cycle takes priority over the timeout
  assign timeout_hit = (state == S_WAIT_B) && !in_hs && (timer == 8'(TIMEOUT - 1));
  productor_top u_productor (
    .data0_i (a_q),
    .data1_i (b_q),
    .result_o(result)
  );
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE && in_hs)   ? S_WAIT_B :
              (state == S_WAIT_B && in_hs) ? S_EXEC   :
              timeout_hit                  ? S_IDLE   :
              (state == S_EXEC)            ? S_OUT    :
              (state == S_OUT && out_hs)   ? S_IDLE   : state;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      timer         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      out_data_o    <= '0;
      op_count_o    <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= (state == S_WAIT_B) ? timer + 8'd1 : 8'd0;
      a_q           <= (state == S_IDLE && in_hs) ? in_data_i : a_q;
      b_q           <= (state == S_WAIT_B && in_hs) ? in_data_i : b_q;
      out_data_o    <= (state == S_EXEC) ? result : out_data_o;
      op_count_o    <= op_count_o + 8'(out_hs);
      err_timeout_o <= timeout_hit;
    end
  end
endmodule

// File: tb/tb_operand_sequencer_top.sv
// tb_operand_sequencer_top: randomized scoreboard bench with a queue-based product/count/timeout model
module tb_operand_sequencer_top;
  localparam int T = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, err_timeout;
  logic [7:0] out_data, op_count;
  int checks = 0, errors = 0, cyc = 0, model_cnt = 0, rdy_mode = 2;
  bit mon_en = 0, exp_err = 0, pv = 0, pr = 0, phs = 0;
  logic [7:0] pd = 0;
  logic [7:0] res_q[$];
  int lat_q[$];
  int err_q[$];

  operand_sequencer_top #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .op_count_o(op_count), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor: compares against the model whenever the DUT presents something
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_err = err_q.size() > 0 && err_q[0] == cyc;
      if (exp_err) void'(err_q.pop_front());
      chk("err_timeout", err_timeout, exp_err);
      chk("op_count", op_count, model_cnt);
      if (out_valid) chk("in_ready_busy", in_ready, 0);
      if (out_valid && !pv) begin
        if (lat_q.size() > 0) chk("latency", cyc, lat_q.pop_front() + 1);
        else chk("unexpected_valid", 1, 0);
      end
      if (pv && !pr && out_valid) chk("hold_data", out_data, pd);
      if (phs) begin
        chk("idle_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);
      end
      if (out_valid && out_ready) begin
        if (res_q.size() > 0) chk("product", out_data, res_q.pop_front());
        else chk("extra_result", 1, 0);
        model_cnt = (model_cnt + 1) % 256;
      end
      pv = out_valid; pr = out_ready; pd = out_data; phs = out_valid && out_ready;
    end
  end

  task automatic stuck(input string name);
    errors++;
    $display("FAIL %s: wait bound expired", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready) begin
      @(negedge clk);
      if (++n > 300) stuck("wait_ready");
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid) begin
      @(negedge clk);
      if (++n > 300) stuck("wait_valid");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (res_q.size() > 0 || out_valid || !in_ready) begin
      @(negedge clk);
      if (++n > 1000) stuck("drain");
    end
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int gap);
    wait_ready();
    in_valid = 1; in_data = a;
    @(negedge clk);
    in_valid = 0; in_data = 8'($urandom);
    repeat (gap) @(negedge clk);
    chk("ready_wait_b", in_ready, 1);
    in_valid = 1; in_data = b;
    res_q.push_back(8'((int'(a) * int'(b)) % 256));
    lat_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic a_only(input logic [7:0] a);
    wait_ready();
    in_valid = 1; in_data = a;
    err_q.push_back(cyc + 1 + T);
    @(negedge clk);
    in_valid = 0;
    repeat (T + 2) @(negedge clk);
    chk("idle_after_timeout", in_ready, 1);
  endtask

  initial begin
    int c0, n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1; mon_en = 1;
    send_op(8'h0C, 8'h0A, 0);
    drain();
    chk("basic_data", out_data, 8'h78);
    chk("basic_count", op_count, 1);
    send_op(8'h20, 8'h10, 1);
    drain();
    chk("trunc_zero", out_data, 8'h00);
    send_op(8'hFF, 8'hFF, 0);
    drain();
    chk("trunc_ff", out_data, 8'h01);
    rdy_mode = 1;
    send_op(8'h37, 8'h5B, 2);
    wait_valid();
    c0 = op_count;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_count", op_count, c0);
    end
    rdy_mode = 2;
    drain();
    chk("bp_count_inc", op_count, (c0 + 1) % 256);
    a_only(8'h05);
    send_op(8'h03, 8'h03, 0);
    drain();
    chk("after_timeout", out_data, 8'h09);
    send_op(8'h11, 8'h0E, T - 1);
    drain();
    chk("b_on_timeout_cycle", out_data, 8'hEE);
    rdy_mode = 0;
    n = 256 - model_cnt;
    repeat (n) begin
      if ($urandom_range(0, 15) == 0) a_only(8'($urandom));
      send_op(8'($urandom), 8'($urandom), int'($urandom_range(0, T - 1)));
    end
    drain();
    chk("count_wrap", op_count, 0);
    rdy_mode = 1;
    send_op(8'h09, 8'h09, 0);
    wait_valid();
    mon_en = 0;
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", op_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    res_q.delete(); lat_q.delete(); err_q.delete();
    model_cnt = 0; pv = 0; pr = 0; phs = 0;
    rst_n = 1; mon_en = 1; rdy_mode = 2;
    send_op(8'h06, 8'h07, 1);
    drain();
    chk("post_rst_data", out_data, 8'h2A);
    chk("post_rst_count", op_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
